// File: rtl/envelope_follower.sv
// -----------------------------------------------------------------------------
// envelope_follower
//
// Tracks the amplitude envelope of a signed audio stream. The follower rises
// quickly toward louder samples (attack), holds its peak for a programmable
// number of sample ticks, and then decays toward quieter samples (release).
// A gate flag reports whether the envelope is at or above a threshold.
//
// Pipeline:
//   stage 1 : on sample_tick_i, register the saturated magnitude |data_i|
//   stage 2 : one cycle later, update env_o / gate_o / FSM and pulse
//             env_valid_o (tick-to-valid latency is 2 cycles)
//
// Ports:
//   clk_i          single clock
//   rst_i          asynchronous active-high reset
//   sample_tick_i  one-cycle strobe marking a new data_i sample
//   enable_i       follower enable, sampled at stage 2
//   data_i         signed two's-complement sample (DW bits)
//   attack_i       attack shift 0..15, sampled at stage 2
//   release_i      release shift 0..15, sampled at stage 2
//   hold_len_i     hold time in sample ticks, sampled at stage 2
//   threshold_i    gate threshold (EW bits), sampled at stage 2
//   env_o          registered envelope (EW bits, unsigned)
//   env_valid_o    one-cycle strobe marking an env_o update
//   gate_o         registered flag, env_o >= threshold_i
// -----------------------------------------------------------------------------
module envelope_follower #(
    parameter int DW = 24,
    parameter int EW = DW - 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          sample_tick_i,
    input  logic          enable_i,
    input  logic [DW-1:0] data_i,
    input  logic [3:0]    attack_i,
    input  logic [3:0]    release_i,
    input  logic [7:0]    hold_len_i,
    input  logic [EW-1:0] threshold_i,
    output logic [EW-1:0] env_o,
    output logic          env_valid_o,
    output logic          gate_o
);

    // Magnitude width: |data_i| of a DW-bit signed value fits in DW-1 bits
    // once the most negative value is saturated.
    localparam int MW = DW - 1;
    // Working width wide enough for both the magnitude and the EW+1-bit
    // envelope arithmetic, so the envelope-range clamp below is lossless.
    localparam int XW = (MW > EW + 1) ? MW : EW + 1;

    typedef enum logic [1:0] {
        ATTACK  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Stage 1: saturated absolute value
    // ------------------------------------------------------------------
    logic [MW-1:0] abs_val;
    logic [MW-1:0] neg_low;
    logic [MW-1:0] mag_q;
    logic          s1_valid_q;

    // Negation only needs the low MW bits. The most negative input has all
    // low bits zero, and its magnitude is clamped to the largest positive value.
    always_comb begin
        neg_low = ~data_i[MW-1:0] + MW'(1);
        if (!data_i[DW-1]) begin
            abs_val = data_i[MW-1:0];
        end else if (data_i[MW-1:0] == '0) begin
            abs_val = '1;
        end else begin
            abs_val = neg_low;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mag_q      <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= sample_tick_i;
            if (sample_tick_i) begin
                mag_q <= abs_val;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: envelope arithmetic
    // ------------------------------------------------------------------
    logic [XW-1:0] mag_wide;
    logic [XW-1:0] env_limit;
    logic [EW:0]   mag_e;
    logic [EW:0]   env_e;
    logic [EW:0]   diff_up;
    logic [EW:0]   diff_dn;
    logic [EW:0]   step_up;
    logic [EW:0]   step_dn;
    logic [EW:0]   sum_up;
    logic [EW:0]   sum_dn;
    logic [EW-1:0] env_up;
    logic [EW-1:0] env_dn;

    // Differences use one extra bit so neither direction can wrap. A step
    // always moves at least one LSB, so the envelope converges exactly
    // instead of stalling once the shifted difference reaches zero.
    always_comb begin
        mag_wide  = XW'(mag_q);
        env_limit = XW'({EW{1'b1}});
        if (mag_wide > env_limit) begin
            mag_e = env_limit[EW:0];
        end else begin
            mag_e = mag_wide[EW:0];
        end
        env_e   = {1'b0, env_o};
        diff_up = mag_e - env_e;
        diff_dn = env_e - mag_e;
        step_up = diff_up >> attack_i;
        step_dn = diff_dn >> release_i;
        if (step_up == '0) begin
            step_up = (EW + 1)'(1);
        end
        if (step_dn == '0) begin
            step_dn = (EW + 1)'(1);
        end
        sum_up = env_e + step_up;
        sum_dn = env_e - step_dn;
        // The step never exceeds the difference, so these clamps only guard
        // against wrap and never change a normal result.
        env_up = sum_up[EW] ? {EW{1'b1}} : sum_up[EW-1:0];
        env_dn = sum_dn[EW] ? '0 : sum_dn[EW-1:0];
    end

    // ------------------------------------------------------------------
    // Stage 2: FSM and output registers
    // ------------------------------------------------------------------
    state_t        state_q;
    state_t        state_n;
    logic [7:0]    hold_cnt_q;
    logic [7:0]    hold_cnt_n;
    logic [EW-1:0] env_n;
    logic          gate_n;
    logic          valid_n;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RELEASE;
            hold_cnt_q  <= '0;
            env_o       <= '0;
            gate_o      <= 1'b0;
            env_valid_o <= 1'b0;
        end else begin
            state_q     <= state_n;
            hold_cnt_q  <= hold_cnt_n;
            env_o       <= env_n;
            gate_o      <= gate_n;
            env_valid_o <= valid_n;
        end
    end

    // A louder sample always wins and re-enters ATTACK from any state.
    // Otherwise ATTACK hands over to HOLD, HOLD counts down, and RELEASE
    // decays toward the sample. Without a stage-2 update, every register
    // keeps its value.
    always_comb begin
        state_n    = state_q;
        hold_cnt_n = hold_cnt_q;
        env_n      = env_o;
        gate_n     = gate_o;
        valid_n    = 1'b0;

        if (s1_valid_q) begin
            valid_n = 1'b1;
            if (!enable_i) begin
                state_n    = RELEASE;
                hold_cnt_n = '0;
                env_n      = '0;
                gate_n     = 1'b0;
            end else begin
                if (mag_e > env_e) begin
                    state_n = ATTACK;
                    env_n   = env_up;
                end else begin
                    case (state_q)
                        ATTACK: begin
                            state_n    = HOLD;
                            hold_cnt_n = hold_len_i;
                        end
                        HOLD: begin
                            if (hold_cnt_q == '0) begin
                                state_n = RELEASE;
                            end else begin
                                hold_cnt_n = hold_cnt_q - 8'd1;
                            end
                        end
                        RELEASE: begin
                            if (mag_e < env_e) begin
                                env_n = env_dn;
                            end
                        end
                        default: begin
                            state_n = RELEASE;
                        end
                    endcase
                end
                gate_n = (env_n >= threshold_i);
            end
        end
    end

endmodule

// File: tb/tb_envelope_follower.sv
// -----------------------------------------------------------------------------
// tb_envelope_follower
//
// Directed, table-driven bench for envelope_follower. Single-tick vectors
// carry their own hand-computed expected envelope and gate. Back-to-back
// attack smoothing and the asynchronous reset are driven as hand-written
// sequences.
// -----------------------------------------------------------------------------
module tb_envelope_follower;

    localparam int DW = 24;
    localparam int EW = DW - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_tick;
    logic          enable;
    logic [DW-1:0] data;
    logic [3:0]    attack;
    logic [3:0]    release_shift;
    logic [7:0]    hold_len;
    logic [EW-1:0] threshold;
    logic [EW-1:0] env;
    logic          env_valid;
    logic          gate;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [3:0]    atk;
        logic [3:0]    rel;
        logic [7:0]    hold;
        logic [EW-1:0] thr;
        logic          en;
        logic [EW-1:0] exp_env;
        logic          exp_gate;
    } vec_t;

    vec_t vecs[$];

    envelope_follower #(.DW(DW), .EW(EW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .sample_tick_i (sample_tick),
        .enable_i      (enable),
        .data_i        (data),
        .attack_i      (attack),
        .release_i     (release_shift),
        .hold_len_i    (hold_len),
        .threshold_i   (threshold),
        .env_o         (env),
        .env_valid_o   (env_valid),
        .gate_o        (gate)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic addVec(input int d, input int atk, input int rel, input int hold,
                          input int thr, input logic en, input int e, input logic g);
        vec_t v;
        v.data     = d[DW-1:0];
        v.atk      = atk[3:0];
        v.rel      = rel[3:0];
        v.hold     = hold[7:0];
        v.thr      = thr[EW-1:0];
        v.en       = en;
        v.exp_env  = e[EW-1:0];
        v.exp_gate = g;
        vecs.push_back(v);
    endtask

    // Drives one tick at a negedge; controls stay put through stage 2.
    // Returns the number of cycles until env_valid was seen (bounded).
    task automatic applyStimulus(input vec_t v, output int lat);
        data          = v.data;
        attack        = v.atk;
        release_shift = v.rel;
        hold_len      = v.hold;
        threshold     = v.thr;
        enable        = v.en;
        sample_tick   = 1'b1;
        lat           = 0;
        do begin
            @(negedge clk);
            sample_tick = 1'b0;
            lat++;
        end while (!env_valid && lat < 8);
    endtask

    task automatic checkOutput(input string tag, input vec_t v, input int lat);
        check({tag, " latency"}, 64'(lat), 64'd2);
        check({tag, " valid"}, 64'(env_valid), 64'd1);
        check({tag, " env"}, 64'(env), 64'(v.exp_env));
        check({tag, " gate"}, 64'(gate), 64'(v.exp_gate));
        @(negedge clk);
        check({tag, " strobe end"}, 64'(env_valid), 64'd0);
        check({tag, " env stable"}, 64'(env), 64'(v.exp_env));
    endtask

    initial begin
        int   lat;
        int   smooth_exp [11];
        vec_t v;
        bit   stray_valid;

        smooth_exp = '{500, 750, 875, 937, 968, 984, 992, 996, 998, 999, 1000};

        rst           = 1'b1;
        sample_tick   = 1'b0;
        enable        = 1'b1;
        data          = '0;
        attack        = '0;
        release_shift = '0;
        hold_len      = '0;
        threshold     = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset env", 64'(env), 64'd0);
        check("reset valid", 64'(env_valid), 64'd0);
        check("reset gate", 64'(gate), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Instant attack
        v = '{data: 24'd10000, atk: 4'd0, rel: 4'd0, hold: 8'd0, thr: 23'd500,
              en: 1'b1, exp_env: 23'd10000, exp_gate: 1'b1};
        applyStimulus(v, lat);
        checkOutput("instant", v, lat);

        // Disable clears the envelope and returns to RELEASE
        v = '{data: 24'd10000, atk: 4'd0, rel: 4'd0, hold: 8'd0, thr: 23'd500,
              en: 1'b0, exp_env: 23'd0, exp_gate: 1'b0};
        applyStimulus(v, lat);
        checkOutput("disable", v, lat);

        // Smoothed attack on back-to-back ticks: step = max(1, (1000-env)>>1)
        data          = 24'd1000;
        attack        = 4'd1;
        release_shift = 4'd0;
        hold_len      = 8'd0;
        threshold     = 23'd900;
        enable        = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c >= 2 && c < 13) begin
                check($sformatf("smooth%0d valid", c - 2), 64'(env_valid), 64'd1);
                check($sformatf("smooth%0d env", c - 2), 64'(env), 64'(smooth_exp[c - 2]));
                check($sformatf("smooth%0d gate", c - 2), 64'(gate),
                      (smooth_exp[c - 2] >= 900) ? 64'd1 : 64'd0);
            end else if (c == 13) begin
                check("smooth strobe end", 64'(env_valid), 64'd0);
                check("smooth final env", 64'(env), 64'd1000);
            end
            sample_tick = (c < 11);
            @(negedge clk);
        end

        // Table: data, atk, rel, hold, thr, en, expected env, expected gate
        // Hold then release from 1000 (state ATTACK)
        addVec(0, 0, 0, 3, 500, 1'b1, 1000, 1'b1);
        addVec(0, 0, 0, 3, 500, 1'b1, 1000, 1'b1);
        addVec(0, 0, 0, 3, 500, 1'b1, 1000, 1'b1);
        addVec(0, 0, 0, 3, 500, 1'b1, 1000, 1'b1);
        addVec(0, 0, 0, 3, 500, 1'b1, 1000, 1'b1);
        addVec(0, 0, 0, 3, 500, 1'b1, 0, 1'b0);
        // Enable low then re-enable
        addVec(1000, 0, 0, 0, 500, 1'b1, 1000, 1'b1);
        addVec(1000, 0, 0, 0, 500, 1'b0, 0, 1'b0);
        addVec(200, 0, 0, 0, 500, 1'b1, 200, 1'b0);
        // Smoothed release, shift 2
        addVec(0, 0, 2, 0, 0, 1'b1, 200, 1'b1);
        addVec(0, 0, 2, 0, 0, 1'b1, 200, 1'b1);
        addVec(0, 0, 2, 0, 0, 1'b1, 150, 1'b1);
        addVec(0, 0, 2, 0, 0, 1'b1, 113, 1'b1);
        addVec(0, 0, 2, 0, 0, 1'b1, 85, 1'b1);
        // Negative sample equal to env, then small-step attacks
        addVec(-85, 0, 0, 0, 0, 1'b1, 85, 1'b1);
        addVec(-100, 3, 0, 0, 0, 1'b1, 86, 1'b1);
        addVec(-100, 15, 0, 0, 0, 1'b1, 87, 1'b1);
        // Most negative sample saturates, then release to 5
        addVec(-8388608, 0, 0, 0, 8388607, 1'b1, 8388607, 1'b1);
        addVec(-5, 0, 0, 0, 8388607, 1'b1, 8388607, 1'b1);
        addVec(-5, 0, 0, 0, 8388607, 1'b1, 8388607, 1'b1);
        addVec(-5, 0, 0, 0, 8388607, 1'b1, 5, 1'b0);
        addVec(-5, 0, 0, 0, 0, 1'b1, 5, 1'b1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], lat);
            checkOutput($sformatf("vec%0d", i), vecs[i], lat);
        end

        // Asynchronous reset with a sample sitting in stage 1
        data        = 24'd1000;
        attack      = 4'd0;
        threshold   = 23'd0;
        enable      = 1'b1;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async reset env", 64'(env), 64'd0);
        check("async reset valid", 64'(env_valid), 64'd0);
        check("async reset gate", 64'(gate), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        stray_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (env_valid) stray_valid = 1'b1;
        end
        check("no valid after reset", 64'(stray_valid), 64'd0);

        v = '{data: 24'd300, atk: 4'd0, rel: 4'd0, hold: 8'd0, thr: 23'd0,
              en: 1'b1, exp_env: 23'd300, exp_gate: 1'b1};
        applyStimulus(v, lat);
        checkOutput("post reset", v, lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
